linked_list_mqueue: RTL
=======================

Name: linked_list_mqueue

Overview:
- Multi-queue FIFO in which NUM_QUEUES logical queues share one DEPTH-entry data store.
- Each queue is a singly linked list. Unused entries form a linked free list.
- Successor to the single-port-pair linked-list FIFO. Adds:
  - per-queue reserved capacity
  - graceful rejection of illegal push/pop, with no environment assumptions
  - simultaneous push and pop, including to the same queue
  - registered pop data with valid
  - occupancy outputs for formal and debug

Parameters:
WIDTH, 8, data width in bits
DEPTH, 8, total shared entries; power of 2, at least 2
NUM_QUEUES, 2, number of logical queues; at least 1
RESERVE, 2, entries guaranteed per queue; elaboration error unless NUM_QUEUES*RESERVE <= DEPTH
Derived (localparam): PTR_W = clog2(DEPTH), SEL_W = max(1, clog2(NUM_QUEUES)), CNT_W = clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
push  in  1  push request
push_sel  in  SEL_W  target queue of push
push_data  in  WIDTH  data to push
pop  in  1  pop request
pop_sel  in  SEL_W  source queue of pop
pop_valid  out  1  pop_data is valid this cycle
pop_data  out  WIDTH  data popped on the previous cycle
empty  out  NUM_QUEUES  per-queue empty flags
full  out  NUM_QUEUES  bit q set means a push to queue q would be rejected
free_count  out  CNT_W  number of entries on the free list
occupancy  out  NUM_QUEUES*CNT_W  per-queue counts, flattened; queue q occupies bits [q*CNT_W +: CNT_W]
err_push  out  1  one-cycle pulse: push rejected
err_pop  out  1  one-cycle pulse: pop rejected

Behaviour:
- State:
  - data memory DEPTH x WIDTH and next-pointer memory DEPTH x PTR_W
  - per queue: head, tail, count
  - free list: free_head, free_tail, free_count
- Reset (synchronous, takes priority over every other event, including mid-operation):
  - next[i] = i+1 for i < DEPTH-1; free_head = 0; free_tail = DEPTH-1; free_count = DEPTH
  - all counts = 0
  - pop_valid = 0, pop_data = 0, err_push = 0, err_pop = 0
  - empty = all ones; full = all zeros
- Outputs derived combinationally from registered state only:
  - empty[q] = (count[q] == 0)
  - shared_used = sum over q of max(0, count[q] - RESERVE)
  - full[q] = (count[q] >= RESERVE) && (shared_used >= DEPTH - NUM_QUEUES*RESERVE)
  - Reserved entries are never consumed by other queues; full is never set for a queue with count < RESERVE.
- Push acceptance:
  - accepted iff push && push_sel < NUM_QUEUES && !full[push_sel]
  - otherwise err_push = 1 next cycle and no state change
  - Accepted push: entry e = free_head; data[e] = push_data; free_head = next[e]; free_count decrements.
  - Accepted push to an empty queue: head = tail = e. Otherwise next[tail] = e and tail = e. count increments.
- Pop acceptance:
  - accepted iff pop && pop_sel < NUM_QUEUES && !empty[pop_sel]
  - otherwise err_pop = 1 next cycle and pop_valid = 0
  - Accepted pop: pop_data <= data[head], pop_valid <= 1 (latency 1 cycle). head = next[head]; count decrements.
  - The freed entry is appended to the free-list tail: next[free_tail] = h, free_tail = h, free_count increments.
  - When free_count was 0, the freed entry h becomes both free_head and free_tail.
  - pop_data holds its last value when pop_valid = 0.
- Simultaneous push and pop:
  - Both are evaluated against pre-cycle state.
  - An entry freed by a pop is not usable by a same-cycle push; it is usable the next cycle.
  - free_count changes by +1, -1 or 0 accordingly.
  - Same queue with count 1: the pop returns the old head. The queue ends with count 1 and head = tail = the new entry.
  - Same queue with count 0: the pop is rejected (err_pop) and the push proceeds.
  - Free-list edge: free_count 1 with push and pop together. The pushed entry leaves the list and the popped entry becomes the sole free entry.
- Invariants (verification asserts):
  - free_count + sum(count) == DEPTH
  - the free list and every queue list are disjoint
  - per-queue ordering is FIFO

Test Plan:
- Common configuration for all scenarios: WIDTH=8, DEPTH=8, NUM_QUEUES=2, RESERVE=2.
- Reset; push 0x11, 0x22, 0x33 to q0; pop q0 x3 -> pop_data 0x11, 0x22, 0x33, each valid one cycle after its pop; empty[0]=1; free_count=8.
- Push 0xA0 to q0, 0xB0 to q1, 0xA1 to q0; pop q1, then q0 x2 -> 0xB0, 0xA0, 0xA1; occupancy all 0.
- Push 6 to q0 -> full[0]=1, full[1]=0; push 2 to q1 accepted, free_count=0; push q0 -> err_push=1, no state change.
- q0 holds 0x55 (count 1); push 0x66 to q0 and pop q0 in the same cycle -> pop_data 0x55, count[0]=1; next pop -> 0x66.
- Pop q1 while empty -> err_pop=1, pop_valid=0, state unchanged. Assert rst while q0 holds 3 entries -> next cycle all empty, free_count=8, outputs at reset values.
- 40 cycles of random legal push/pop to both queues -> per-queue order preserved, conservation invariant holds every cycle, free list wraps without loss.

Source files
------------

// File: rtl/linked_list_mqueue.sv
// Multi-queue FIFO: NUM_QUEUES linked-list queues share one DEPTH-entry store,
// with unused entries chained on a free list and RESERVE entries guaranteed per queue.
module linked_list_mqueue #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_QUEUES = 2,
  parameter int RESERVE    = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int SEL_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [SEL_W-1:0]            push_sel,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic [SEL_W-1:0]            pop_sel,
  output logic                        pop_valid,
  output logic [WIDTH-1:0]            pop_data,
  output logic [NUM_QUEUES-1:0]       empty,
  output logic [NUM_QUEUES-1:0]       full,
  output logic [CNT_W-1:0]            free_count,
  output logic [NUM_QUEUES*CNT_W-1:0] occupancy,
  output logic                        err_push,
  output logic                        err_pop
);

  localparam int NSEL = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] RES_C      = CNT_W'(RESERVE);
  localparam logic [CNT_W-1:0] SHARED_CAP = CNT_W'(DEPTH - NUM_QUEUES * RESERVE);

  if (NUM_QUEUES * RESERVE > DEPTH) begin : g_bad_reserve
    $error("linked_list_mqueue: NUM_QUEUES*RESERVE exceeds DEPTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("linked_list_mqueue: DEPTH must be a power of 2 and at least 2");
  end
  if (NUM_QUEUES < 1) begin : g_bad_queues
    $error("linked_list_mqueue: NUM_QUEUES must be at least 1");
  end

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0] next_mem [DEPTH];
  logic [PTR_W-1:0] head     [NUM_QUEUES];
  logic [PTR_W-1:0] tail     [NUM_QUEUES];
  logic [CNT_W-1:0] count    [NUM_QUEUES];
  logic [PTR_W-1:0] free_head;
  logic [PTR_W-1:0] free_tail;
  logic [CNT_W-1:0] free_cnt;

  logic [CNT_W-1:0] shared_used;
  logic [NSEL-1:0]  full_ext;
  logic [NSEL-1:0]  empty_ext;
  logic             push_acc;
  logic             pop_acc;
  logic             same_q;
  logic [PTR_W-1:0] push_entry;
  logic [PTR_W-1:0] pop_entry;
  logic [PTR_W-1:0] pop_next_head;
  logic [PTR_W-1:0] push_next_free;

  always_comb begin
    shared_used = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (count[q] > RES_C) shared_used = shared_used + (count[q] - RES_C);
    end
  end

  always_comb begin
    empty     = '0;
    full      = '0;
    occupancy = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      empty[q] = (count[q] == '0);
      full[q]  = (count[q] >= RES_C) && (shared_used >= SHARED_CAP);
      occupancy[q*CNT_W +: CNT_W] = count[q];
    end
  end

  // Selector codes beyond NUM_QUEUES look permanently full and empty, so they are rejected.
  always_comb begin
    full_ext  = '1;
    empty_ext = '1;
    full_ext[NUM_QUEUES-1:0]  = full;
    empty_ext[NUM_QUEUES-1:0] = empty;
  end

  assign free_count = free_cnt;
  assign push_acc   = push && !full_ext[push_sel];
  assign pop_acc    = pop && !empty_ext[pop_sel];
  assign same_q     = push_acc && pop_acc && (push_sel == pop_sel);
  assign push_entry = free_head;
  assign pop_entry  = head[pop_sel];

  // next[] of a sole element or sole free entry is being rewritten this cycle, so bypass it.
  assign pop_next_head  = (same_q && count[pop_sel] == CNT_W'(1)) ? push_entry
                                                                  : next_mem[pop_entry];
  assign push_next_free = (pop_acc && free_cnt == CNT_W'(1)) ? pop_entry
                                                             : next_mem[push_entry];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) next_mem[i] <= PTR_W'((i + 1) % DEPTH);
      for (int q = 0; q < NUM_QUEUES; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= '0;
      end
      free_head <= '0;
      free_tail <= PTR_W'(DEPTH - 1);
      free_cnt  <= CNT_W'(DEPTH);
      pop_valid <= 1'b0;
      pop_data  <= '0;
      err_push  <= 1'b0;
      err_pop   <= 1'b0;
    end else begin
      err_push  <= push && !push_acc;
      err_pop   <= pop && !pop_acc;
      pop_valid <= pop_acc;
      if (pop_acc) pop_data <= data_mem[pop_entry];

      if (push_acc) begin
        free_head <= push_next_free;
        if (count[push_sel] == '0) head[push_sel] <= push_entry;
        else next_mem[tail[push_sel]] <= push_entry;
        tail[push_sel] <= push_entry;
      end

      // A popped entry joins the free-list tail; it cannot collide with a same-cycle push.
      if (pop_acc) begin
        head[pop_sel]       <= pop_next_head;
        next_mem[free_tail] <= pop_entry;
        free_tail           <= pop_entry;
        if (free_cnt == '0) free_head <= pop_entry;
      end

      for (int q = 0; q < NUM_QUEUES; q++) begin
        count[q] <= count[q] + CNT_W'(push_acc && push_sel == SEL_W'(q))
                             - CNT_W'(pop_acc && pop_sel == SEL_W'(q));
      end
      free_cnt <= free_cnt - CNT_W'(push_acc) + CNT_W'(pop_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) data_mem[push_entry] <= push_data;
  end

endmodule
